// File: rtl/fmrv32im_cache_pkg.sv
// Shared definitions for the fmrv32im data cache: controller states,
// cacheable region and address field widths.
package fmrv32im_cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB_REQ,
        ST_WB_WAIT,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_FL_SCAN,
        ST_FL_REQ,
        ST_FL_WAIT
    } cache_state_t;

    localparam logic [1:0] CACHE_REGION = 2'b00;

    function automatic int off_bits(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int idx_bits(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_bits(input int line_words, input int num_lines);
        return 30 - off_bits(line_words) - idx_bits(num_lines);
    endfunction

endpackage

// File: rtl/fmrv32im_cache_ram.sv
// Dual-port line storage: port A serves refill writes and write-back reads,
// port B is the CPU side with byte enables. Both read ports are registered.
module fmrv32im_cache_ram #(
  parameter int DEPTH    = 1024,
  parameter int AW       = 10,
  parameter     MEM_FILE = ""
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [31:0]   wdata_a,
  output logic [31:0]   rdata_a,
  input  logic          re_b,
  input  logic [3:0]    wstb_b,
  input  logic [AW-1:0] addr_b,
  input  logic [31:0]   wdata_b,
  output logic [31:0]   rdata_b
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we_a)
      mem[addr_a] <= wdata_a;
    for (int b = 0; b < 4; b++)
      if (wstb_b[b])
        mem[addr_b][8*b +: 8] <= wdata_b[8*b +: 8];
  end

  // Port B only refreshes on a read so the CPU-visible data holds between reads.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      rdata_a <= mem[addr_a];
      if (re_b)
        rdata_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/fmrv32im_dmcache.sv
// Direct-mapped write-back data cache for fmrv32im with line refill/write-back
// through an external AXI master and a whole-cache flush sequence.
module fmrv32im_dmcache
    import fmrv32im_cache_pkg::*;
#(
    parameter int LINE_WORDS = 256,
    parameter int NUM_LINES  = 4,
    parameter     MEM_FILE   = ""
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          MEM_ENA,
    input  logic [3:0]                    MEM_WSTB,
    input  logic [31:0]                   MEM_ADDR,
    input  logic [31:0]                   MEM_WDATA,
    output logic                          MEM_WAIT,
    output logic [31:0]                   MEM_RDATA,
    output logic                          MEM_BADMEM_EXCPT,
    input  logic                          FLUSH,
    output logic                          FLUSH_DONE,
    output logic                          WR_REQ_START,
    output logic [31:0]                   WR_REQ_ADDR,
    output logic [15:0]                   WR_REQ_LEN,
    input  logic                          WR_REQ_READY,
    input  logic [$clog2(LINE_WORDS)-1:0] WR_REQ_MEM_ADDR,
    output logic [31:0]                   WR_REQ_MEM_WDATA,
    output logic                          RD_REQ_START,
    output logic [31:0]                   RD_REQ_ADDR,
    output logic [15:0]                   RD_REQ_LEN,
    input  logic                          RD_REQ_READY,
    input  logic                          RD_REQ_MEM_WE,
    input  logic [$clog2(LINE_WORDS)-1:0] RD_REQ_MEM_ADDR,
    input  logic [31:0]                   RD_REQ_MEM_RDATA
);

    localparam int LB    = $clog2(LINE_WORDS);
    localparam int OB    = off_bits(LINE_WORDS);
    localparam int IB    = idx_bits(NUM_LINES);
    localparam int IW    = (IB > 0) ? IB : 1;
    localparam int TW    = tag_bits(LINE_WORDS, NUM_LINES);
    localparam int AW    = LB + IB;
    localparam int DEPTH = NUM_LINES * LINE_WORDS;
    localparam logic [15:0] LEN_BYTES = 16'(LINE_WORDS * 4);

    cache_state_t         state, state_nx;
    logic [TW-1:0]        tags [NUM_LINES];
    logic [NUM_LINES-1:0] valid, dirty;
    logic [IW-1:0]        idx, miss_idx, scan, wb_line;
    logic [TW-1:0]        tag, miss_tag;
    logic                 flush_pend;
    logic                 cacheable, hit, miss, accept, victim_dirty, scan_dirty, scan_last;
    logic                 ram_we_a;
    logic [AW-1:0]        ram_addr_a, ram_addr_b;

    function automatic logic [31:0] line_addr(input logic [TW-1:0] t, input logic [IW-1:0] l);
        return (32'(t) << (OB + IB)) | ((32'(l) & 32'(NUM_LINES - 1)) << OB);
    endfunction

    assign idx          = IW'((MEM_ADDR >> OB) & 32'(NUM_LINES - 1));
    assign tag          = TW'(MEM_ADDR[29:0] >> (OB + IB));
    assign cacheable    = (MEM_ADDR[31:30] == CACHE_REGION);
    assign hit          = MEM_ENA & cacheable & valid[idx] & (tags[idx] == tag);
    assign miss         = MEM_ENA & cacheable & ~hit;
    assign accept       = hit & (state == ST_IDLE);
    assign victim_dirty = valid[idx] & dirty[idx];
    assign scan_dirty   = valid[scan] & dirty[scan];
    assign scan_last    = (scan == IW'(NUM_LINES - 1));

    assign MEM_WAIT         = MEM_ENA & cacheable & (~hit | (state != ST_IDLE));
    assign MEM_BADMEM_EXCPT = MEM_ENA & ~cacheable;

    // Port A: refill writes while the read master streams, otherwise the write-back line.
    assign wb_line    = (state == ST_FL_REQ || state == ST_FL_WAIT || state == ST_FL_SCAN) ? scan : miss_idx;
    assign ram_we_a   = RD_REQ_MEM_WE & (state == ST_RD_WAIT);
    assign ram_addr_a = (state == ST_RD_WAIT) ? ((AW'(miss_idx) << LB) | AW'(RD_REQ_MEM_ADDR))
                                              : ((AW'(wb_line) << LB) | AW'(WR_REQ_MEM_ADDR));
    assign ram_addr_b = AW'(MEM_ADDR >> 2);

    fmrv32im_cache_ram #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .MEM_FILE(MEM_FILE)
    ) u_ram (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .we_a   (ram_we_a),
        .addr_a (ram_addr_a),
        .wdata_a(RD_REQ_MEM_RDATA),
        .rdata_a(WR_REQ_MEM_WDATA),
        .re_b   (accept & (MEM_WSTB == 4'b0000)),
        .wstb_b (accept ? MEM_WSTB : 4'b0000),
        .addr_b (ram_addr_b),
        .wdata_b(MEM_WDATA),
        .rdata_b(MEM_RDATA)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (FLUSH | flush_pend)
                    state_nx = ST_FL_SCAN;
                else if (miss & victim_dirty & WR_REQ_READY)
                    state_nx = ST_WB_REQ;
                else if (miss & ~victim_dirty & RD_REQ_READY)
                    state_nx = ST_RD_REQ;
            end
            ST_WB_REQ:  state_nx = ST_WB_WAIT;
            ST_WB_WAIT: if (WR_REQ_READY) state_nx = ST_RD_REQ;
            ST_RD_REQ:  state_nx = ST_RD_WAIT;
            ST_RD_WAIT: if (RD_REQ_READY) state_nx = ST_IDLE;
            ST_FL_SCAN: begin
                if (scan_dirty) begin
                    if (WR_REQ_READY) state_nx = ST_FL_REQ;
                end else if (scan_last) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_FL_REQ:  state_nx = ST_FL_WAIT;
            ST_FL_WAIT: if (WR_REQ_READY) state_nx = ST_FL_SCAN;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        WR_REQ_START = (state == ST_WB_REQ) | (state == ST_FL_REQ);
        RD_REQ_START = (state == ST_RD_REQ);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            valid       <= '0;
            dirty       <= '0;
            flush_pend  <= 1'b0;
            scan        <= '0;
            miss_idx    <= '0;
            miss_tag    <= '0;
            FLUSH_DONE  <= 1'b0;
            WR_REQ_ADDR <= '0;
            WR_REQ_LEN  <= '0;
            RD_REQ_ADDR <= '0;
            RD_REQ_LEN  <= '0;
            for (int i = 0; i < NUM_LINES; i++)
                tags[i] <= '0;
        end else begin
            state      <= state_nx;
            FLUSH_DONE <= 1'b0;
            if (FLUSH & (state != ST_IDLE))
                flush_pend <= 1'b1;
            if (accept & (MEM_WSTB != 4'b0000))
                dirty[idx] <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (FLUSH | flush_pend) begin
                        flush_pend <= 1'b0;
                        scan       <= '0;
                    end else if (miss) begin
                        miss_idx <= idx;
                        miss_tag <= tag;
                    end
                    if (state_nx == ST_WB_REQ) begin
                        WR_REQ_ADDR <= line_addr(tags[idx], idx);
                        WR_REQ_LEN  <= LEN_BYTES;
                    end
                    if (state_nx == ST_RD_REQ) begin
                        RD_REQ_ADDR <= line_addr(tag, idx);
                        RD_REQ_LEN  <= LEN_BYTES;
                    end
                end
                ST_WB_WAIT: if (WR_REQ_READY) begin
                    dirty[miss_idx] <= 1'b0;
                    RD_REQ_ADDR     <= line_addr(miss_tag, miss_idx);
                    RD_REQ_LEN      <= LEN_BYTES;
                end
                ST_RD_WAIT: if (RD_REQ_READY) begin
                    tags[miss_idx]  <= miss_tag;
                    valid[miss_idx] <= 1'b1;
                    dirty[miss_idx] <= 1'b0;
                end
                ST_FL_SCAN: begin
                    if (scan_dirty) begin
                        if (WR_REQ_READY) begin
                            WR_REQ_ADDR <= line_addr(tags[scan], scan);
                            WR_REQ_LEN  <= LEN_BYTES;
                        end
                    end else if (scan_last) begin
                        valid      <= '0;
                        FLUSH_DONE <= 1'b1;
                    end else begin
                        scan <= IW'(scan + 1'b1);
                    end
                end
                ST_FL_WAIT: if (WR_REQ_READY) dirty[scan] <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fmrv32im_dmcache.sv
// Directed bench for fmrv32im_dmcache with behavioural AXI read/write masters
// backed by a sparse memory model and request scoreboards.
module tb_fmrv32im_dmcache;

    localparam int LW = 16;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        MEM_ENA;
    logic [3:0]  MEM_WSTB;
    logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
    logic        MEM_WAIT, MEM_BADMEM_EXCPT;
    logic        FLUSH, FLUSH_DONE;
    logic        WR_REQ_START, WR_REQ_READY;
    logic [31:0] WR_REQ_ADDR, WR_REQ_MEM_WDATA;
    logic [15:0] WR_REQ_LEN;
    logic [3:0]  WR_REQ_MEM_ADDR;
    logic        RD_REQ_START, RD_REQ_READY, RD_REQ_MEM_WE;
    logic [31:0] RD_REQ_ADDR, RD_REQ_MEM_RDATA;
    logic [15:0] RD_REQ_LEN;
    logic [3:0]  RD_REQ_MEM_ADDR;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          wr_pulses = 0;
    int          rd_fill_cnt = 0;
    bit          rd_busy = 1'b0;
    logic [31:0] exp_rd_q[$];
    logic [31:0] exp_wr_q[$];
    logic [31:0] exp_rdata_q[$];
    logic [31:0] bmem [logic [31:0]];

    always #5 CLK = ~CLK;

    fmrv32im_dmcache #(.LINE_WORDS(LW), .NUM_LINES(4), .MEM_FILE("")) dut (
        .CLK(CLK), .RST_N(RST_N),
        .MEM_ENA(MEM_ENA), .MEM_WSTB(MEM_WSTB), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_WAIT(MEM_WAIT), .MEM_RDATA(MEM_RDATA), .MEM_BADMEM_EXCPT(MEM_BADMEM_EXCPT),
        .FLUSH(FLUSH), .FLUSH_DONE(FLUSH_DONE),
        .WR_REQ_START(WR_REQ_START), .WR_REQ_ADDR(WR_REQ_ADDR), .WR_REQ_LEN(WR_REQ_LEN),
        .WR_REQ_READY(WR_REQ_READY), .WR_REQ_MEM_ADDR(WR_REQ_MEM_ADDR), .WR_REQ_MEM_WDATA(WR_REQ_MEM_WDATA),
        .RD_REQ_START(RD_REQ_START), .RD_REQ_ADDR(RD_REQ_ADDR), .RD_REQ_LEN(RD_REQ_LEN),
        .RD_REQ_READY(RD_REQ_READY), .RD_REQ_MEM_WE(RD_REQ_MEM_WE), .RD_REQ_MEM_ADDR(RD_REQ_MEM_ADDR),
        .RD_REQ_MEM_RDATA(RD_REQ_MEM_RDATA)
    );

    function automatic logic [31:0] bfn(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0] + 16'h1234};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return bfn(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Read master: streams a line from the backing model, aborts on reset.
    initial begin : rd_master
        logic [31:0] exp_a;
        RD_REQ_READY = 1'b1; RD_REQ_MEM_WE = 1'b0; RD_REQ_MEM_ADDR = '0; RD_REQ_MEM_RDATA = '0;
        forever begin
            @(negedge CLK);
            if (RST_N === 1'b1 && RD_REQ_START === 1'b1) begin
                exp_a = (exp_rd_q.size() != 0) ? exp_rd_q.pop_front() : 32'hFFFF_FFFF;
                check("rd_req_addr", RD_REQ_ADDR, exp_a);
                check("rd_req_len", 32'(RD_REQ_LEN), 32'd64);
                RD_REQ_READY = 1'b0; rd_fill_cnt = 0; rd_busy = 1'b1;
                for (int i = 0; i < LW; i++) begin
                    @(negedge CLK);
                    if (RST_N !== 1'b1) break;
                    RD_REQ_MEM_WE = 1'b1; RD_REQ_MEM_ADDR = 4'(i);
                    RD_REQ_MEM_RDATA = mem_word(exp_a + 32'(4 * i));
                    rd_fill_cnt = i + 1;
                end
                if (RST_N === 1'b1) begin
                    @(negedge CLK);
                    if (RST_N === 1'b1) check("rd_addr_stable", RD_REQ_ADDR, exp_a);
                end
                RD_REQ_MEM_WE = 1'b0; RD_REQ_READY = 1'b1; rd_busy = 1'b0;
            end
        end
    end

    // Write master: pulls a line (one-cycle read latency) into the backing model.
    initial begin : wr_master
        logic [31:0] exp_a;
        WR_REQ_READY = 1'b1; WR_REQ_MEM_ADDR = '0;
        forever begin
            @(negedge CLK);
            if (RST_N === 1'b1 && WR_REQ_START === 1'b1) begin
                exp_a = (exp_wr_q.size() != 0) ? exp_wr_q.pop_front() : 32'hFFFF_FFFF;
                check("wr_req_addr", WR_REQ_ADDR, exp_a);
                check("wr_req_len", 32'(WR_REQ_LEN), 32'd64);
                wr_pulses++;
                WR_REQ_READY = 1'b0;
                @(negedge CLK);
                WR_REQ_MEM_ADDR = '0;
                for (int i = 0; i < LW; i++) begin
                    @(negedge CLK);
                    bmem[exp_a + 32'(4 * i)] = WR_REQ_MEM_WDATA;
                    if (i < LW - 1) WR_REQ_MEM_ADDR = 4'(i + 1);
                end
                check("wr_addr_stable", WR_REQ_ADDR, exp_a);
                WR_REQ_READY = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    task automatic wait_ready(input string tag);
        int n = 0;
        while (MEM_WAIT === 1'b1 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_wait_bound"}, 32'(n < 2000), 32'd1);
    endtask

    task automatic cpu_read(input logic [31:0] a, input logic [31:0] exp);
        exp_rdata_q.push_back(exp);
        @(negedge CLK);
        MEM_ENA = 1'b1; MEM_WSTB = 4'h0; MEM_ADDR = a;
        #1;
        wait_ready("rd");
        @(posedge CLK); #1;
        check($sformatf("rdata@%h", a), MEM_RDATA, exp_rdata_q.pop_front());
        MEM_ENA = 1'b0;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] stb);
        @(negedge CLK);
        MEM_ENA = 1'b1; MEM_WSTB = stb; MEM_ADDR = a; MEM_WDATA = d;
        #1;
        wait_ready("wr");
        @(posedge CLK); #1;
        MEM_ENA = 1'b0; MEM_WSTB = 4'h0;
    endtask

    initial begin : stimulus
        logic [31:0] w, exp44;
        int n, p0;
        RST_N = 1'b0; MEM_ENA = 1'b0; MEM_WSTB = '0; MEM_ADDR = '0; MEM_WDATA = '0; FLUSH = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_wait", 32'(MEM_WAIT), 32'd0);
        check("rst_rdata", MEM_RDATA, 32'd0);
        check("rst_flush_done", 32'(FLUSH_DONE), 32'd0);
        check("rst_wr_start", 32'(WR_REQ_START), 32'd0);
        check("rst_rd_start", 32'(RD_REQ_START), 32'd0);
        check("rst_rd_addr", RD_REQ_ADDR, 32'd0);
        check("rst_wr_len", 32'(WR_REQ_LEN), 32'd0);
        RST_N = 1'b1;

        // Cold miss, refill, then hits in the same line.
        exp_rd_q.push_back(32'h40);
        cpu_read(32'h40, bfn(32'h40));
        cpu_read(32'h7C, bfn(32'h7C));

        // Partial write hit keeps the upper half.
        cpu_write(32'h44, 32'hDEAD_BEEF, 4'h3);
        w = bfn(32'h44);
        exp44 = {w[31:16], 16'hBEEF};
        cpu_read(32'h44, exp44);

        // Conflict miss on a dirty line: write-back first, then refill.
        exp_wr_q.push_back(32'h40);
        exp_rd_q.push_back(32'h140);
        cpu_read(32'h140, bfn(32'h140));
        check("wb_data_0x44", mem_word(32'h44), exp44);
        exp_rd_q.push_back(32'h40);
        cpu_read(32'h44, exp44);

        // Uncacheable access.
        @(negedge CLK);
        MEM_ENA = 1'b1; MEM_WSTB = 4'h0; MEM_ADDR = 32'h8000_0000;
        #1;
        check("badmem_excpt", 32'(MEM_BADMEM_EXCPT), 32'd1);
        check("badmem_wait", 32'(MEM_WAIT), 32'd0);
        repeat (3) @(negedge CLK);
        check("badmem_no_rd_start", 32'(RD_REQ_START), 32'd0);
        check("badmem_no_wr_start", 32'(WR_REQ_START), 32'd0);
        MEM_ENA = 1'b0;
        #1;
        check("badmem_clear", 32'(MEM_BADMEM_EXCPT), 32'd0);

        // Flush with lines 0 and 2 dirty, line 1 clean.
        exp_rd_q.push_back(32'h0);
        cpu_write(32'h0, 32'h1111_2222, 4'hF);
        exp_rd_q.push_back(32'h80);
        cpu_write(32'h80, 32'h3333_4444, 4'hF);
        p0 = wr_pulses;
        exp_wr_q.push_back(32'h0);
        exp_wr_q.push_back(32'h80);
        @(negedge CLK); FLUSH = 1'b1;
        @(negedge CLK); FLUSH = 1'b0;
        n = 0;
        while (FLUSH_DONE !== 1'b1 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        check("flush_done_bound", 32'(n < 2000), 32'd1);
        @(negedge CLK);
        check("flush_done_pulse", 32'(FLUSH_DONE), 32'd0);
        check("flush_wr_pulses", 32'(wr_pulses - p0), 32'd2);
        check("flush_wb_line2", mem_word(32'h80), 32'h3333_4444);
        exp_rd_q.push_back(32'h40);
        cpu_read(32'h40, mem_word(32'h40));
        exp_rd_q.push_back(32'h0);
        cpu_read(32'h0, 32'h1111_2222);

        // Reset in the middle of a refill.
        exp_rd_q.push_back(32'h200);
        @(negedge CLK);
        MEM_ENA = 1'b1; MEM_WSTB = 4'h0; MEM_ADDR = 32'h200;
        n = 0;
        while (!(rd_busy && rd_fill_cnt >= 4) && n < 500) begin
            @(negedge CLK);
            n++;
        end
        check("rd_fill_bound", 32'(n < 500), 32'd1);
        RST_N = 1'b0;
        #1;
        check("midrst_wait", 32'(MEM_WAIT), 32'd1);
        check("midrst_rd_start", 32'(RD_REQ_START), 32'd0);
        check("midrst_rd_addr", RD_REQ_ADDR, 32'd0);
        repeat (2) @(negedge CLK);
        exp_rd_q.push_back(32'h200);
        RST_N = 1'b1;
        #1;
        wait_ready("midrst");
        @(posedge CLK); #1;
        check("midrst_rdata", MEM_RDATA, bfn(32'h200));
        MEM_ENA = 1'b0;
        exp_rd_q.push_back(32'h0);
        cpu_read(32'h0, 32'h1111_2222);

        repeat (4) @(negedge CLK);
        check("rd_q_drained", 32'(exp_rd_q.size()), 32'd0);
        check("wr_q_drained", 32'(exp_wr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fmrv32im_dmcache.md
FMRV32IM_DMCACHE -- requirements
Module: fmrv32im_dmcache

Interface
REQ-001 Parameter LINE_WORDS, default 256, words per line; power of two, 16..1024.
REQ-002 Parameter NUM_LINES, default 4, lines per cache; power of two, 1..16.
REQ-003 Parameter MEM_FILE, default "", optional RAM init image, ignored when empty.
REQ-004 Derived: OB = log2(LINE_WORDS)+2 offset bits; IB = log2(NUM_LINES) index bits; tag = ADDR[29:OB+IB]; RAM index = ADDR[OB+IB-1:2].
REQ-005 CLK  in  1  sole clock, rising edge.
REQ-006 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-007 MEM_ENA  in  1  CPU access request.
REQ-008 MEM_WSTB  in  4  byte write strobes; 0 means read.
REQ-009 MEM_ADDR  in  32  CPU byte address.
REQ-010 MEM_WDATA  in  32  CPU write data.
REQ-011 MEM_WAIT  out  1  stall; access not accepted this cycle.
REQ-012 MEM_RDATA  out  32  read data, valid one cycle after acceptance.
REQ-013 MEM_BADMEM_EXCPT  out  1  access outside cacheable region.
REQ-014 FLUSH  in  1  pulse: write back all dirty lines, invalidate all.
REQ-015 FLUSH_DONE  out  1  one-cycle pulse on flush completion.
REQ-016 WR_REQ_START/ADDR[31:0]/LEN[15:0]  out  AXI-master write request; WR_REQ_READY  in  1  master idle.
REQ-017 WR_REQ_MEM_ADDR  in  log2(LINE_WORDS)  word within line; WR_REQ_MEM_WDATA  out  32  line data, 1-cycle latency.
REQ-018 RD_REQ_START/ADDR[31:0]/LEN[15:0]  out  read request; RD_REQ_READY  in  1; RD_REQ_MEM_WE  in  1; RD_REQ_MEM_ADDR  in  log2(LINE_WORDS); RD_REQ_MEM_RDATA  in  32.

Function
REQ-019 Cacheable region: ADDR[31:30]==2'b00; other addresses with MEM_ENA assert MEM_BADMEM_EXCPT combinationally, never WAIT, never write RAM.
REQ-020 Direct-mapped; per line: tag, valid, dirty registers.
REQ-021 Hit = MEM_ENA & cacheable & valid[idx] & tag match; MEM_WAIT = MEM_ENA & cacheable & (~hit | state!=IDLE), combinational.
REQ-022 Accepted read hit: MEM_RDATA = word at RAM index, registered, next cycle; MEM_RDATA holds otherwise.
REQ-023 Accepted write hit: byte lanes per MEM_WSTB written that edge; dirty[idx] set.
REQ-024 States: IDLE, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, FL_SCAN, FL_REQ, FL_WAIT.
REQ-025 IDLE, miss, victim dirty, WR_REQ_READY -> WB_REQ; ADDR = {2'b00, victim tag, idx, OB zeros}.
REQ-026 IDLE, miss, victim clean/invalid, RD_REQ_READY -> RD_REQ; ADDR = {MEM_ADDR[31:OB], OB zeros}.
REQ-027 WB_REQ: WR_REQ_START high exactly one cycle -> WB_WAIT; WB_WAIT, WR_REQ_READY -> RD_REQ, dirty cleared.
REQ-028 RD_REQ: RD_REQ_START one cycle -> RD_WAIT; RD_REQ_MEM_WE writes {idx, RD_REQ_MEM_ADDR}; WAIT on RD_REQ_READY -> IDLE, tag written, valid=1, dirty=0.
REQ-029 LEN = LINE_WORDS*4 bytes on both channels; ADDR held stable from START until READY returns.
REQ-030 FLUSH seen in IDLE (priority over miss) -> FL_SCAN with line counter 0; FLUSH while busy is latched, serviced on return to IDLE.
REQ-031 FL_SCAN: dirty line -> FL_REQ/FL_WAIT write-back (as REQ-027) then clear dirty; clean line skipped one cycle; after line NUM_LINES-1 clear all valid, pulse FLUSH_DONE, -> IDLE.
REQ-032 Write-back RAM read port addressed {line, WR_REQ_MEM_ADDR}; CPU port write never collides since WAIT is high outside IDLE.
REQ-033 Same-cycle miss-resolve and new access: hit evaluated on updated tag from next cycle only.

Reset
REQ-034 RST_N low asynchronously: state=IDLE, all valid/dirty=0, tags=0, START pulses=0, FLUSH_DONE=0, ADDR/LEN=0, MEM_RDATA=0, flush latch=0.
REQ-035 RAM contents not reset; reset mid-transfer abandons transfer, master handles its own reset.

Structure
REQ-036 Package fmrv32im_cache_pkg: state encoding, region constant 2'b00, offset/index/tag width functions.
REQ-037 One sub-module fmrv32im_cache_ram: true dual-port, byte-enable port B, registered outputs, depth NUM_LINES*LINE_WORDS.

Verification (LINE_WORDS=16, NUM_LINES=4)
REQ-038 Read 0x0000_0040 cold -> RD_REQ_START, ADDR 0x40, LEN 64; fill 16 words; WAIT drops; RDATA = filled word 0.
REQ-039 Write 0xDEADBEEF WSTB 0x3 to 0x44 hit, then read 0x44 -> RDATA low half 0xBEEF, upper unchanged.
REQ-040 Access 0x0000_0140 (same index, new tag) after REQ-039 -> WR_REQ ADDR 0x40 LEN 64 first, then RD_REQ ADDR 0x140.
REQ-041 Read 0x8000_0000 -> BADMEM_EXCPT=1, WAIT=0, no START pulse.
REQ-042 FLUSH with lines 0,2 dirty -> exactly two WR_REQ pulses (index order), FLUSH_DONE one pulse, next access misses.
REQ-043 RST_N low during RD_WAIT -> state IDLE immediately, valid all 0, WAIT reasserted for pending access.
